// File: rtl/slicevm_pkg.sv
// rtl/slicevm_pkg.sv - shared width defaults and saturating adder for slicevm_acc
package slicevm_pkg;

  localparam int DWIDTH_D  = 8;
  localparam int CWIDTH_D  = 9;
  localparam int AWIDTH_D  = 32;
  localparam int NCH_D     = 2;
  localparam int WINCOLS_D = 8;
  localparam int WINROWS_D = 4;
  localparam int WPI_D     = 40;

  typedef struct packed {
    logic [63:0] sum;
    logic        clamp;
  } sat_res_t;

  // Adds two sign-extended operands; when sat is set the result is clamped to
  // the signed w-bit range, otherwise the caller truncates and the sum wraps.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w, input logic sat);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t r;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sum   = s;
    r.clamp = 1'b0;
    if (sat && (s > hi)) begin
      r.sum   = hi;
      r.clamp = 1'b1;
    end else if (sat && (s < lo)) begin
      r.sum   = lo;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slicevm_acc_if.sv
// rtl/slicevm_acc_if.sv - pixel stream, bias and score bundle of slicevm_acc
interface slicevm_acc_if #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 9,
  parameter int AWIDTH = 32,
  parameter int NCH    = 2
);
  logic                    dvi;
  logic [DWIDTH-1:0]       data;
  logic [NCH*CWIDTH-1:0]   svcoeff;
  logic                    newblock;
  logic                    download;
  logic [NCH*AWIDTH-1:0]   bias;
  logic [NCH*AWIDTH-1:0]   score;
  logic                    score_valid;
  logic [NCH-1:0]          msb;
  logic [NCH-1:0]          ovf;

  modport master (output dvi, data, svcoeff, newblock, download, bias,
                  input  score, score_valid, msb, ovf);
  modport slave  (input  dvi, data, svcoeff, newblock, download, bias,
                  output score, score_valid, msb, ovf);
endinterface

// File: rtl/slicevm_linebuf.sv
// rtl/slicevm_linebuf.sv - circular partial-sum line buffer, sync write, registered read-old
module slicevm_linebuf #(
  parameter int WPI   = 40,
  parameter int WIDTH = 64,
  localparam int PTRW = (WPI > 1) ? $clog2(WPI) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTRW-1:0]  wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTRW-1:0]  rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [WPI];

  // Block-RAM style port: a same-edge write to rd_addr is not seen by this read.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/slicevm_acc.sv
// rtl/slicevm_acc.sv - sliding-window MAC with line-carried partial sums; SLICEVM_ACC_SAT_EN enables saturation
module slicevm_acc
  import slicevm_pkg::*;
#(
  parameter int DWIDTH  = DWIDTH_D,
  parameter int CWIDTH  = CWIDTH_D,
  parameter int AWIDTH  = AWIDTH_D,
  parameter int NCH     = NCH_D,
  parameter int WINCOLS = WINCOLS_D,
  parameter int WINROWS = WINROWS_D,
  parameter int WPI     = WPI_D
) (
  input logic          clk,
  input logic          reset,
  slicevm_acc_if.slave bus
);
  localparam int PW   = CWIDTH + DWIDTH + 1;
  localparam int PTRW = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int BCW  = (WINCOLS > 1) ? $clog2(WINCOLS) : 1;
  localparam int RCW  = (WINROWS > 1) ? $clog2(WINROWS) : 1;
`ifdef SLICEVM_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [BCW-1:0]  blockcount;
  logic [RCW-1:0]  rowcount;
  logic [PTRW-1:0] ptr;
  logic            first_pend;

  logic                   s1_valid, s1_first, s1_last, s1_final;
  logic [PTRW-1:0]        s1_ptr;
  logic signed [PW-1:0]   s1_p [NCH];
  logic                   s1_byp;
  logic [NCH*AWIDTH-1:0]  s1_byp_data;
  logic signed [AWIDTH-1:0] acc [NCH];

  logic [NCH*AWIDTH-1:0]  score_r;
  logic                   score_valid_r;
  logic [NCH-1:0]         msb_r, ovf_r;

  logic signed [PW-1:0]     prod [NCH];
  logic signed [AWIDTH-1:0] acc_new [NCH];
  logic signed [AWIDTH-1:0] score_new [NCH];
  logic [NCH-1:0]           clamp;
  logic [NCH*AWIDTH-1:0]    acc_new_flat, rd_data, rd_sel;
  logic                     lb_we, last, final_row, ptr_wrap, blk_wrap;
  logic [PTRW-1:0]          lb_waddr, ptr_nxt;
  logic [NCH*AWIDTH-1:0]    lb_wdata;

  assign blk_wrap  = (blockcount == BCW'(WINCOLS - 1));
  assign last      = bus.dvi & bus.newblock & blk_wrap;
  assign final_row = (rowcount == RCW'(WINROWS - 1));
  assign ptr_wrap  = (ptr == PTRW'(WPI - 1));
  assign ptr_nxt   = ptr_wrap ? '0 : ptr + 1'b1;

  // Download owns the write port; otherwise a completing window stores its
  // partial sum, or zero on the final row so the entry starts the next window clean.
  assign lb_we    = bus.download | (s1_valid & s1_last);
  assign lb_waddr = bus.download ? ptr : s1_ptr;
  assign lb_wdata = (bus.download | s1_final) ? '0 : acc_new_flat;

  slicevm_linebuf #(.WPI(WPI), .WIDTH(NCH*AWIDTH)) u_linebuf (
    .clk     (clk),
    .we      (lb_we),
    .wr_addr (lb_waddr),
    .wr_data (lb_wdata),
    .rd_addr (ptr),
    .rd_data (rd_data)
  );

  // Products, accumulate/bias adders and the line-buffer bypass select.
  always_comb begin
    logic signed [AWIDTH-1:0] base;
    sat_res_t r_acc, r_sc;
    base = '0;
    r_acc = '0;
    r_sc = '0;
    clamp = '0;
    acc_new_flat = '0;
    rd_sel = s1_byp ? s1_byp_data : rd_data;
    for (int c = 0; c < NCH; c++) begin
      prod[c] = PW'($signed(bus.svcoeff[c*CWIDTH +: CWIDTH])) * PW'($signed({1'b0, bus.data}));
      base = s1_first ? $signed(rd_sel[c*AWIDTH +: AWIDTH]) : acc[c];
      r_acc = sat_add(64'(base), 64'(s1_p[c]), AWIDTH, SAT_EN);
      acc_new[c] = r_acc.sum[AWIDTH-1:0];
      r_sc = sat_add(64'(acc_new[c]), 64'($signed(bus.bias[c*AWIDTH +: AWIDTH])), AWIDTH, SAT_EN);
      score_new[c] = r_sc.sum[AWIDTH-1:0];
      clamp[c] = r_acc.clamp | (s1_last & s1_final & r_sc.clamp);
      acc_new_flat[c*AWIDTH +: AWIDTH] = acc_new[c];
    end
  end

  // Stage 0 tags the sample and steps the counters; stage 1 accumulates and scores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blockcount <= '0; rowcount <= '0; ptr <= '0; first_pend <= 1'b1;
      s1_valid <= 1'b0; s1_first <= 1'b0; s1_last <= 1'b0; s1_final <= 1'b0;
      s1_ptr <= '0; s1_byp <= 1'b0; s1_byp_data <= '0;
      score_r <= '0; score_valid_r <= 1'b0; msb_r <= '0; ovf_r <= '0;
      for (int c = 0; c < NCH; c++) begin
        s1_p[c] <= '0;
        acc[c] <= '0;
      end
    end else if (bus.download) begin
      blockcount <= '0; rowcount <= '0; ptr <= ptr_nxt; first_pend <= 1'b1;
      s1_valid <= 1'b0; s1_byp <= 1'b0; score_valid_r <= 1'b0; ovf_r <= '0;
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
    end else begin
      score_valid_r <= 1'b0;
      s1_valid <= bus.dvi;
      s1_byp <= lb_we && (lb_waddr == ptr);
      s1_byp_data <= lb_wdata;
      if (bus.dvi) begin
        for (int c = 0; c < NCH; c++) s1_p[c] <= prod[c];
        s1_first <= first_pend;
        s1_last <= last;
        s1_final <= final_row;
        s1_ptr <= ptr;
        first_pend <= last;
        if (bus.newblock) blockcount <= blk_wrap ? '0 : blockcount + 1'b1;
        if (last) begin
          ptr <= ptr_nxt;
          if (ptr_wrap) rowcount <= final_row ? '0 : rowcount + 1'b1;
        end
      end
      if (s1_valid) begin
        for (int c = 0; c < NCH; c++) acc[c] <= acc_new[c];
        ovf_r <= ovf_r | clamp;
        if (s1_last && s1_final) begin
          score_valid_r <= 1'b1;
          for (int c = 0; c < NCH; c++) begin
            score_r[c*AWIDTH +: AWIDTH] <= score_new[c];
            msb_r[c] <= !score_new[c][AWIDTH-1] && (score_new[c] != '0);
          end
        end
      end
    end
  end

  assign bus.score       = score_r;
  assign bus.score_valid = score_valid_r;
  assign bus.msb         = msb_r;
  assign bus.ovf         = ovf_r & {NCH{SAT_EN}};
endmodule

// File: tb/tb_slicevm_acc.sv
// tb/tb_slicevm_acc.sv - randomized and directed bench for slicevm_acc against a window-sum model
module tb_slicevm_acc;
  localparam int DW = 8, CW = 9, AW = 32, NC = 2, WC = 2, WR = 2, WP = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slicevm_acc_if #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .NCH(NC)) bus();
  slicevm_acc #(.DWIDTH(DW), .CWIDTH(CW), .AWIDTH(AW), .NCH(NC),
                .WINCOLS(WC), .WINROWS(WR), .WPI(WP)) dut (.clk(clk), .reset(reset), .bus(bus));

  slicevm_acc_if #(.DWIDTH(DW), .CWIDTH(10), .AWIDTH(16), .NCH(NC)) wbus();
  slicevm_acc #(.DWIDTH(DW), .CWIDTH(10), .AWIDTH(16), .NCH(NC),
                .WINCOLS(WC), .WINROWS(WR), .WPI(WP)) dut_w (.clk(clk), .reset(reset), .bus(wbus));

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: windows counted per line position, partial sums per position.
  typedef struct { longint cyc; longint s0; longint s1; longint msb; } exp_t;
  exp_t exp_q[$];
  longint m_part [WP][NC];
  longint m_cur [NC];
  int m_blk = 0, m_pos = 0, m_row = 0;
  longint bias0 = 0, bias1 = 0;

  task automatic m_sample(input int d, input int c0, input int c1, input bit nb);
    exp_t e;
    m_cur[0] += longint'(c0) * d;
    m_cur[1] += longint'(c1) * d;
    if (nb) begin
      m_blk++;
      if (m_blk == WC) begin
        m_blk = 0;
        if (m_row == WR - 1) begin
          e.cyc = cyc + 2;
          e.s0 = longint'(int'(m_part[m_pos][0] + m_cur[0] + bias0));
          e.s1 = longint'(int'(m_part[m_pos][1] + m_cur[1] + bias1));
          e.msb = (e.s0 > 0 ? 1 : 0) + (e.s1 > 0 ? 2 : 0);
          exp_q.push_back(e);
          m_part[m_pos][0] = 0; m_part[m_pos][1] = 0;
        end else begin
          m_part[m_pos][0] += m_cur[0]; m_part[m_pos][1] += m_cur[1];
        end
        m_cur[0] = 0; m_cur[1] = 0;
        m_pos++;
        if (m_pos == WP) begin
          m_pos = 0;
          m_row = (m_row + 1) % WR;
        end
      end
    end
  endtask

  task automatic m_download();
    m_part[m_pos][0] = 0; m_part[m_pos][1] = 0;
    m_pos = (m_pos + 1) % WP;
    m_blk = 0; m_row = 0; m_cur[0] = 0; m_cur[1] = 0;
  endtask

  task automatic put(input bit v, input int d, input int c0, input int c1, input bit nb, input bit dl);
    bus.dvi = v; bus.data = DW'(d); bus.svcoeff = {CW'(c1), CW'(c0)};
    bus.newblock = nb; bus.download = dl; bus.bias = {AW'(bias1), AW'(bias0)};
    if (dl) m_download();
    else if (v) m_sample(d, c0, c1, nb);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      put(1'b1, 10, 1, -2, 1'b1, 1'b0);
      if (gaps) idle(1);
    end
  endtask

  task automatic wput(input bit v, input bit dl);
    wbus.dvi = v; wbus.data = 8'd255; wbus.svcoeff = {10'd1, 10'd255};
    wbus.newblock = 1'b1; wbus.download = dl; wbus.bias = '0;
    @(posedge clk); #1;
  endtask

  // Every score pulse is matched against the oldest expected window score.
  always @(negedge clk) begin
    exp_t e;
    if (bus.score_valid) begin
      if (exp_q.size() == 0) check("spurious_sv", bus.score_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("sv_cycle", cyc, e.cyc);
        check("score_ch0", $signed(bus.score[31:0]), e.s0);
        check("score_ch1", $signed(bus.score[63:32]), e.s1);
        check("msb", bus.msb, e.msb);
      end
    end
  end

  initial begin
    longint wtot, w0;
    int found, k;
    reset = 1'b1;
    bus.dvi = 0; bus.data = '0; bus.svcoeff = '0; bus.newblock = 0; bus.download = 0; bus.bias = '0;
    wbus.dvi = 0; wbus.data = '0; wbus.svcoeff = '0; wbus.newblock = 0; wbus.download = 0; wbus.bias = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_score", bus.score, 0);
    check("rst_sv", bus.score_valid, 0);
    check("rst_msb", bus.msb, 0);
    check("rst_ovf", bus.ovf, 0);
    reset = 1'b0;

    repeat (WP) put(1'b0, 0, 0, 0, 1'b0, 1'b1);
    stream(12, 1'b0);
    idle(3);
    bias0 = -45; bias1 = 100;
    stream(12, 1'b0);
    idle(3);
    bias0 = 0; bias1 = 0;
    stream(12, 1'b1);
    idle(3);
    stream(7, 1'b0);
    repeat (WP) put(1'b0, 0, 0, 0, 1'b0, 1'b1);
    stream(12, 1'b0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        idle(2);
        bias0 = longint'($urandom_range(0, 2000)) - 1000;
        bias1 = longint'($urandom_range(0, 2000)) - 1000;
        k = $urandom_range(1, 5);
        repeat (k) put(1'b0, 0, 0, 0, 1'b0, 1'b1);
      end else begin
        put($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256,
            1'($urandom_range(0, 1)), 1'b0);
      end
    end
    idle(4);
    check("ovf_main", bus.ovf, 0);

    repeat (WP) wput(1'b0, 1'b1);
    repeat (8) wput(1'b1, 1'b0);
    wput(1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      @(negedge clk);
      if (wbus.score_valid) found = 1;
    end
    check("wide_sv_seen", found, 1);
    wtot = 4 * 255 * 255;
`ifdef SLICEVM_ACC_SAT_EN
    w0 = 32767;
    check("wide_ovf", wbus.ovf, 1);
`else
    w0 = longint'(shortint'(wtot));
    check("wide_ovf", wbus.ovf, 0);
`endif
    check("wide_score_ch0", $signed(wbus.score[15:0]), w0);
    check("wide_score_ch1", $signed(wbus.score[31:16]), 1020);
    check("wide_msb", wbus.msb, (w0 > 0 ? 1 : 0) + 2);
    @(posedge clk); #1;

    bias0 = 0; bias1 = 0;
    k = (WP - m_pos) % WP + WP;
    repeat (k) put(1'b0, 0, 0, 0, 1'b0, 1'b1);
    stream(7, 1'b0);
    bus.dvi = 1; bus.data = 8'd10; bus.svcoeff = {CW'(-2), CW'(1)}; bus.newblock = 1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_score", bus.score, 0);
    check("midrst_sv", bus.score_valid, 0);
    check("midrst_msb", bus.msb, 0);
    check("midrst_ovf", bus.ovf, 0);
    bus.dvi = 0; bus.newblock = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_blk = 0; m_row = 0; m_pos = 0; m_cur[0] = 0; m_cur[1] = 0;
    idle(5);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
